// File: rtl/sha256_pkg.sv
// Shared types, padding constants and byte-swap helpers for the SHA256
// nonce scheduler and its message builder.
package sha256_pkg;

  localparam int HDR_W = 640;
  localparam int BLK_W = 512;

  localparam int PAD_80B_LEN = 640;
  localparam int PAD_32B_LEN = 256;

  typedef enum logic [1:0] {
    BT_HASH        = 2'd0,
    BT_MERKLE_LEAF = 2'd1,
    BT_HEADER      = 2'd2
  } blk_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_W1,
    ST_W2,
    ST_S2,
    ST_W3,
    ST_CHK,
    ST_FIN
  } sched_st_e;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++)
      r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

endpackage

// File: rtl/sha256_msg_pad.sv
// Combinational builder of the two header blocks and the second-pass
// block of a Bitcoin double-SHA256.
module sha256_msg_pad
  import sha256_pkg::*;
(
  input  logic [HDR_W-1:32] hdr,
  input  logic [31:0]       nonce,
  input  logic [255:0]      h1,
  output logic [BLK_W-1:0]  blk1,
  output logic [BLK_W-1:0]  blk2,
  output logic [BLK_W-1:0]  blk3
);

  assign blk1 = hdr[639:128];

  assign blk2 = {hdr[127:32], bswap32(nonce),
                 8'h80, 312'b0, 64'(PAD_80B_LEN)};

  assign blk3 = {h1, 8'h80, 184'b0, 64'(PAD_32B_LEN)};

endmodule

// File: rtl/sha256_nonce_sched.sv
// Walks a nonce range through one SHA256 core (double hash per nonce)
// and reports the first winner. SCHED_STATS_EN adds hash/error stats.
module sha256_nonce_sched
  import sha256_pkg::*;
(
  input  logic               CLK,
  input  logic               nreset,
  input  logic               go,
  input  logic               stop,
  input  logic [HDR_W-1:0]   header,
  input  logic [31:0]        nonce_start,
  input  logic [31:0]        nonce_end,
  input  logic [255:0]       target,
  output logic               core_start,
  output logic [BLK_W-1:0]   core_msg,
  output logic [1:0]         core_blk_type,
  input  logic [255:0]       core_hash,
  input  logic               core_blk_done,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [31:0]        found_nonce,
  output logic [255:0]       found_hash
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]        hash_count,
  output logic               err_spurious_done
`endif
);

  sched_st_e          st_q;
  logic [HDR_W-1:32]  hdr_q;
  logic [31:0]        nonce_q, end_q, nonce_d;
  logic [255:0]       tgt_q, h1_q, h2_q, v_d;
  logic               stop_pend_q;
  logic               start_q, done_q, found_q, busy_q;
  logic [1:0]         btype_q;
  logic [31:0]        fnonce_q;
  logic [255:0]       fhash_q;
  logic [BLK_W-1:0]   blk1, blk2, blk3;
  logic               go_acc;
  logic               unused_nonce_field;

  assign unused_nonce_field = ^header[31:0];
  assign go_acc  = (st_q == ST_IDLE) && go;
  assign nonce_d = nonce_q + 32'd1;
  assign v_d     = bswap256(h2_q);

  sha256_msg_pad u_pad (
    .hdr   (hdr_q),
    .nonce (nonce_q),
    .h1    (h1_q),
    .blk1  (blk1),
    .blk2  (blk2),
    .blk3  (blk3)
  );

  // blk2 must already be on the bus in the done cycle itself
  always_comb begin
    core_msg = '0;
    unique case (st_q)
      ST_S1:        core_msg = blk1;
      ST_W1:        core_msg = core_blk_done ? blk2 : blk1;
      ST_W2:        core_msg = blk2;
      ST_S2, ST_W3: core_msg = blk3;
      default:      core_msg = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      st_q        <= ST_IDLE;
      hdr_q       <= '0;
      nonce_q     <= '0;
      end_q       <= '0;
      tgt_q       <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      stop_pend_q <= 1'b0;
      start_q     <= 1'b0;
      btype_q     <= BT_HASH;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      busy_q      <= 1'b0;
      fnonce_q    <= '0;
      fhash_q     <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      if (st_q != ST_IDLE && stop)
        stop_pend_q <= 1'b1;
      unique case (st_q)
        ST_IDLE: begin
          stop_pend_q <= 1'b0;
          if (go) begin
            hdr_q    <= header[HDR_W-1:32];
            nonce_q  <= nonce_start;
            end_q    <= nonce_end;
            tgt_q    <= target;
            found_q  <= 1'b0;
            fnonce_q <= '0;
            fhash_q  <= '0;
            busy_q   <= 1'b1;
            start_q  <= 1'b1;
            btype_q  <= BT_HEADER;
            st_q     <= ST_S1;
          end
        end
        ST_S1: st_q <= ST_W1;
        ST_W1: if (core_blk_done) st_q <= ST_W2;
        ST_W2: begin
          if (core_blk_done) begin
            h1_q    <= core_hash;
            start_q <= 1'b1;
            btype_q <= BT_HASH;
            st_q    <= ST_S2;
          end
        end
        ST_S2: st_q <= ST_W3;
        ST_W3: begin
          if (core_blk_done) begin
            h2_q <= core_hash;
            st_q <= ST_CHK;
          end
        end
        ST_CHK: begin
          if (v_d <= tgt_q ||
              nonce_q == end_q ||
              stop_pend_q || stop) begin
            found_q  <= (v_d <= tgt_q);
            done_q   <= 1'b1;
            fnonce_q <= nonce_q;
            fhash_q  <= v_d;
            st_q     <= ST_FIN;
          end else begin
            nonce_q <= nonce_d;
            start_q <= 1'b1;
            btype_q <= BT_HEADER;
            st_q    <= ST_S1;
          end
        end
        ST_FIN: begin
          busy_q <= 1'b0;
          st_q   <= ST_IDLE;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [31:0] cnt_q;
  logic        spur_q;
  logic        spur_d;

  assign spur_d = core_blk_done &&
                  (st_q == ST_IDLE || st_q == ST_S1 || st_q == ST_S2);

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= '0;
      spur_q <= 1'b0;
    end else begin
      if (go_acc)
        cnt_q <= '0;
      else if (st_q == ST_CHK)
        cnt_q <= cnt_q + 32'd1;
      spur_q <= go_acc ? 1'b0 : (spur_q | spur_d);
    end
  end

  assign hash_count        = cnt_q;
  assign err_spurious_done = spur_q;
`endif

  assign core_start    = start_q;
  assign core_blk_type = btype_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign found         = found_q;
  assign found_nonce   = fnonce_q;
  assign found_hash    = fhash_q;

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Bench for sha256_nonce_sched: behavioural SHA256 core plus a
// double-SHA search reference model.
module tb_sha256_nonce_sched;

  logic         CLK = 1'b0;
  logic         nreset;
  logic         go, stop;
  logic [639:0] header;
  logic [31:0]  nonce_start, nonce_end;
  logic [255:0] target;
  logic         core_start;
  logic [511:0] core_msg;
  logic [1:0]   core_blk_type;
  logic [255:0] core_hash;
  logic         core_blk_done;
  logic         busy, done, found;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
`ifdef SCHED_STATS_EN
  logic [31:0]  hash_count;
  logic         err_spurious_done;
`endif

  always #5 CLK = ~CLK;

  sha256_nonce_sched dut (
    .CLK           (CLK),
    .nreset        (nreset),
    .go            (go),
    .stop          (stop),
    .header        (header),
    .nonce_start   (nonce_start),
    .nonce_end     (nonce_end),
    .target        (target),
    .core_start    (core_start),
    .core_msg      (core_msg),
    .core_blk_type (core_blk_type),
    .core_hash     (core_hash),
    .core_blk_done (core_blk_done),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .found_nonce   (found_nonce),
    .found_hash    (found_hash)
`ifdef SCHED_STATS_EN
    ,
    .hash_count        (hash_count),
    .err_spurious_done (err_spurious_done)
`endif
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin,
                                            input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25))
             + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22))
         + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c,
            hin[159:128] + d, hin[127:96] + e, hin[95:64] + f,
            hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [31:0] bs32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bs256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  // Bitcoin block hash of the 80-byte header with the nonce spliced in,
  // as the little-endian 256-bit number compared with the target.
  function automatic logic [255:0] dsha(input logic [639:0] hdr,
                                        input logic [31:0] n);
    logic [255:0] h1, h2;
    logic [639:0] m;
    m  = {hdr[639:32], bs32(n)};
    h1 = compress(IV, m[639:128]);
    h1 = compress(h1, {m[127:0], 8'h80, 312'b0, 64'd640});
    h2 = compress(IV, {h1, 8'h80, 184'b0, 64'd256});
    return bs256(h2);
  endfunction

  localparam int C_IDLE = 0, C_B1 = 1, C_G1 = 2, C_G2 = 3, C_B2 = 4;
  int           cst;
  int           ccnt;
  logic         cbt2;
  logic [255:0] cmid;
  logic [31:0]  tried_arr [256];
  int           tried_n = 0;
  logic [639:0] cur_hdr = '0;
  int           msg_err = 0;
  int           start_err = 0;
  logic         prev_start = 1'b0;

  always @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      cst           <= C_IDLE;
      ccnt          <= 0;
      cbt2          <= 1'b0;
      cmid          <= '0;
      core_blk_done <= 1'b0;
      core_hash     <= '0;
    end else begin
      core_blk_done <= 1'b0;
      case (cst)
        C_IDLE: if (core_start) begin
          cbt2 <= (core_blk_type == 2'd2);
          cmid <= compress(IV, core_msg);
          ccnt <= int'($urandom_range(3, 8));
          cst  <= C_B1;
        end
        C_B1: if (ccnt == 0) begin
          core_blk_done <= 1'b1;
          core_hash     <= cmid;
          cst           <= cbt2 ? C_G1 : C_IDLE;
        end else ccnt <= ccnt - 1;
        C_G1: cst <= C_G2;
        C_G2: begin
          cmid <= compress(cmid, core_msg);
          tried_arr[tried_n % 256] <= bs32(core_msg[415:384]);
          tried_n <= tried_n + 1;
          ccnt <= int'($urandom_range(3, 8));
          cst  <= C_B2;
        end
        C_B2: if (ccnt == 0) begin
          core_blk_done <= 1'b1;
          core_hash     <= cmid;
          cst           <= C_IDLE;
        end else ccnt <= ccnt - 1;
        default: cst <= C_IDLE;
      endcase
    end
  end

  always @(negedge CLK) begin
    prev_start <= core_start;
    if (core_start && prev_start) start_err <= start_err + 1;
    if (cst == C_G2 &&
        (core_msg[511:416] !== cur_hdr[127:32] ||
         core_msg[383:0] !== {8'h80, 312'b0, 64'd640}))
      msg_err <= msg_err + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic         exp_found;
  logic [31:0]  exp_nonce;
  logic [255:0] exp_hash;
  int           exp_n;
  logic [31:0]  exp_q [256];
  logic [255:0] last_hash;

  task automatic model(input logic [639:0] hdr, input logic [31:0] ns,
                       input logic [31:0] ne, input logic [255:0] tgt,
                       input logic stp);
    logic [31:0]  n;
    logic [255:0] v;
    n = ns;
    v = '0;
    exp_n = 0;
    exp_found = 1'b0;
    for (int k = 0; k < 256; k++) begin
      v = dsha(hdr, n);
      exp_q[k] = n;
      exp_n++;
      if (v <= tgt) begin exp_found = 1'b1; break; end
      if (n == ne || stp) break;
      n = n + 32'd1;
    end
    exp_nonce = n;
    exp_hash  = v;
  endtask

  // mode 0: plain search, 1: stop during W1, 2: reset during W2
  task automatic run(input logic [639:0] hdr, input logic [31:0] ns,
                     input logic [31:0] ne, input logic [255:0] tgt,
                     input int mode);
    int   base;
    logic seen;
    base = tried_n;
    if (mode != 2) model(hdr, ns, ne, tgt, mode == 1);
    cur_hdr = hdr;
    @(negedge CLK);
    header = hdr; nonce_start = ns; nonce_end = ne; target = tgt;
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    chk("busy_after_go", busy, 1'b1);
    if (mode == 2) begin
      seen = 1'b0;
      for (int c = 0; c < 2000 && !seen; c++) begin
        @(negedge CLK);
        if (cst == C_G2 || cst == C_B2) seen = 1'b1;
      end
      chk("w2_reached", seen, 1'b1);
      @(negedge CLK);
      nreset = 1'b0;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_found", found, 1'b0);
      chk("rst_nonce", found_nonce, 32'd0);
      chk("rst_hash", found_hash, 256'd0);
      chk("rst_start", core_start, 1'b0);
      chk("rst_btype", core_blk_type, 2'd0);
      chk("rst_msg", core_msg, 512'd0);
      @(negedge CLK);
      nreset = 1'b1;
      return;
    end
    @(negedge CLK);
    if (mode == 1) stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    header = {20{$urandom}};
    nonce_start = $urandom;
    nonce_end = $urandom;
    target = '1;
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
    chk("found", found, exp_found);
    chk("found_nonce", found_nonce, exp_nonce);
    chk("found_hash", found_hash, exp_hash);
    last_hash = found_hash;
    chk("attempts", 256'(tried_n - base), 256'(exp_n));
    for (int i = 0; i < exp_n && i < tried_n - base; i++)
      chk("tried_nonce", tried_arr[(base + i) % 256], exp_q[i]);
`ifdef SCHED_STATS_EN
    chk("hash_count", hash_count, 32'(exp_n));
`endif
    @(negedge CLK);
    chk("done_pulse", done, 1'b0);
    @(negedge CLK);
    chk("idle_busy", busy, 1'b0);
    chk("hold_nonce", found_nonce, exp_nonce);
    chk("hold_found", found, exp_found);
  endtask

  localparam logic [639:0] GEN_HDR = {
    32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c
  };
  localparam logic [255:0] GEN_TGT = {48'h00000000ffff, 208'b0};
  localparam logic [255:0] GEN_HASH =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  initial begin
    logic [639:0] rh;
    logic [31:0]  rs;
    nreset = 1'b0;
    go = 1'b0; stop = 1'b0;
    header = '0; nonce_start = '0; nonce_end = '0; target = '0;
    last_hash = '0;
    repeat (2) @(negedge CLK);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_found", found, 1'b0);
    chk("reset_start", core_start, 1'b0);
    chk("reset_msg", core_msg, 512'd0);
    nreset = 1'b1;
    @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;

    run(GEN_HDR, 32'h7c2bac1b, 32'h7c2bac1f, GEN_TGT, 0);
    chk("genesis_hash", last_hash, GEN_HASH);
    run(GEN_HDR, 32'h0, 32'h3, 256'd0, 0);
    run(GEN_HDR, 32'hfffffffe, 32'h1, 256'd0, 0);
    run(GEN_HDR, 32'h12345678, 32'h12345677, 256'd0, 1);
    run(GEN_HDR, 32'h0, 32'hffffffff, 256'd0, 2);
    run(GEN_HDR, 32'h7c2bac1d, 32'h7c2bac1d, GEN_TGT, 0);
    for (int t = 0; t < 4; t++) begin
      for (int j = 0; j < 20; j++) rh[32*j +: 32] = $urandom;
      rs = $urandom;
      run(rh, rs, rs + 32'($urandom_range(0, 3)),
          {256{1'b1}} >> $urandom_range(1, 3), 0);
    end

    chk("blk2_layout_errs", 256'(msg_err), 256'd0);
    chk("start_width_errs", 256'(start_err), 256'd0);
`ifdef SCHED_STATS_EN
    chk("err_spurious", err_spurious_done, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
